// File: rtl/clint_port_arbiter.sv
// Two-requester round-robin arbiter that runs one AXI4-Lite read or write per
// grant toward the CLINT register slave and routes the response to the owner.
module clint_port_arbiter #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic [1:0]                req_valid,
  output logic [1:0]                req_ready,
  input  logic [1:0]                req_we,
  input  logic [2*ADDR_WIDTH-1:0]   req_addr,
  input  logic [2*DATA_WIDTH-1:0]   req_wdata,
  input  logic [2*DATA_WIDTH/8-1:0] req_wstrb,
  output logic [1:0]                rsp_valid,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic                      rsp_err,
  output logic [ADDR_WIDTH-1:0]     m_awaddr,
  output logic                      m_awvalid,
  input  logic                      m_awready,
  output logic [DATA_WIDTH-1:0]     m_wdata,
  output logic [DATA_WIDTH/8-1:0]   m_wstrb,
  output logic                      m_wvalid,
  input  logic                      m_wready,
  input  logic [1:0]                m_bresp,
  input  logic                      m_bvalid,
  output logic                      m_bready,
  output logic [ADDR_WIDTH-1:0]     m_araddr,
  output logic                      m_arvalid,
  input  logic                      m_arready,
  input  logic [DATA_WIDTH-1:0]     m_rdata,
  input  logic [1:0]                m_rresp,
  input  logic                      m_rvalid,
  output logic                      m_rready
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_WRESP, S_READ, S_RDATA, S_RESP
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic                    w_accept;
  logic                    w_winner;
  logic                    w_sel_we;
  logic [ADDR_WIDTH-1:0]   w_sel_addr;
  logic [DATA_WIDTH-1:0]   w_sel_wdata;
  logic [STRB_WIDTH-1:0]   w_sel_wstrb;
  logic                    w_unused_resp_lsb;

  logic                    r_last_grant;
  logic                    r_owner;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [STRB_WIDTH-1:0]   r_wstrb;
  logic                    r_awvalid;
  logic                    r_wvalid;
  logic                    r_bready;
  logic                    r_arvalid;
  logic                    r_rready;
  logic [1:0]              r_rsp_valid;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic                    r_err;

  // Only the error bit of a response matters; OKAY vs EXOKAY is not reported.
  assign w_unused_resp_lsb = m_bresp[0] ^ m_rresp[0];

  // Tie goes to whoever was not served last; a lone requester always wins.
  assign w_winner    = (&req_valid) ? ~r_last_grant : req_valid[1];
  assign w_sel_we    = w_winner ? req_we[1] : req_we[0];
  assign w_sel_addr  = w_winner ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
  assign w_sel_wdata = w_winner ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
  assign w_sel_wstrb = w_winner ? req_wstrb[2*STRB_WIDTH-1:STRB_WIDTH] : req_wstrb[STRB_WIDTH-1:0];

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    w_next    = r_state;
    w_accept  = 1'b0;
    req_ready = 2'b00;
    case (r_state)
      S_IDLE: begin
        if ((|req_valid) && !areset) begin
          w_accept            = 1'b1;
          req_ready[w_winner] = 1'b1;
          w_next              = w_sel_we ? S_WRITE : S_READ;
        end
      end
      S_WRITE: begin
        if ((!r_awvalid || m_awready) && (!r_wvalid || m_wready)) w_next = S_WRESP;
      end
      S_WRESP: if (m_bvalid)  w_next = S_RESP;
      S_READ:  if (m_arready) w_next = S_RDATA;
      S_RDATA: if (m_rvalid)  w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Every AXI-facing control bit is a flop loaded from the next state.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_awvalid    <= 1'b0;
      r_wvalid     <= 1'b0;
      r_bready     <= 1'b0;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_rsp_valid  <= 2'b00;
      r_rdata      <= '0;
      r_err        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (w_accept) begin
        r_owner   <= w_winner;
        r_addr    <= w_sel_addr;
        r_wdata   <= w_sel_wdata;
        r_wstrb   <= w_sel_wstrb;
        r_awvalid <= w_sel_we;
        r_wvalid  <= w_sel_we;
      end else begin
        if (r_awvalid && m_awready) r_awvalid <= 1'b0;
        if (r_wvalid && m_wready)   r_wvalid  <= 1'b0;
      end
      r_arvalid   <= (w_next == S_READ);
      r_bready    <= (w_next == S_WRESP);
      r_rready    <= (w_next == S_RDATA);
      r_rsp_valid <= (w_next == S_RESP) ? {r_owner, ~r_owner} : 2'b00;
      if (r_state == S_WRESP && m_bvalid) begin
        r_rdata <= '0;
        r_err   <= m_bresp[1];
      end
      if (r_state == S_RDATA && m_rvalid) begin
        r_rdata <= m_rdata;
        r_err   <= m_rresp[1];
      end
      if (r_state == S_RESP) r_last_grant <= r_owner;
    end
  end

  assign m_awaddr  = r_addr;
  assign m_araddr  = r_addr;
  assign m_wdata   = r_wdata;
  assign m_wstrb   = r_wstrb;
  assign m_awvalid = r_awvalid;
  assign m_wvalid  = r_wvalid;
  assign m_bready  = r_bready;
  assign m_arvalid = r_arvalid;
  assign m_rready  = r_rready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

endmodule
